operand_stack: RTL and testbench

- LIFO operand stack for the 8-bit stack-machine datapath. Sits directly downstream of the 32x8 Memory block.
- PUSH captures the word returned on Memory.resMem. POP hands the top word to Memory.data for a write-back.
- Exposes the top two entries (tos, nos) to the ALU. ALU results go back through a single-cycle replace operation.

---
 rtl/operand_stack_if.sv | 27 ++
 rtl/operand_stack.sv | 98 +++++++++
 tb/tb_operand_stack.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/operand_stack_if.sv
// Bus between the stack-machine controller and the operand stack.
// The controller drives operations; the stack reports its top entries, occupancy and error flags.
interface operand_stack_if #(
    parameter int WIDTH = 8,
    parameter int PW    = 3
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [PW:0]      count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output push, pop, din,
        input  tos, nos, count, empty, full, ovf, unf
    );

    modport slave (
        input  push, pop, din,
        output tos, nos, count, empty, full, ovf, unf
    );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack for the 8-bit stack-machine datapath.
// It supports push, pop and an in-place replace of the top entry, and exposes the top two entries to the ALU.
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    operand_stack_if.slave    bus
);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_C   = (PW+1)'(1);
    localparam logic [PW:0] TWO_C   = (PW+1)'(2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;
    logic             ovf_q;
    logic             unf_q;
    logic             ovf_set;
    logic             unf_set;

    logic             do_push;
    logic             do_pop;
    logic             do_repl;
    logic             is_empty;
    logic             is_full;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic [PW:0]      top_ptr;
    logic [PW:0]      nos_ptr;

    assign do_push  = bus.push & ~bus.pop;
    assign do_pop   = bus.pop & ~bus.push;
    assign do_repl  = bus.push & bus.pop;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);
    assign top_ptr  = count_q - ONE_C;
    assign nos_ptr  = count_q - TWO_C;

    // Replace on an empty stack writes slot 0, which is also count_q, so it shares the push path.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = count_q[PW-1:0];
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (do_push) begin
            if (is_full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + ONE_C;
            end
        end else if (do_pop) begin
            if (is_empty) begin
                unf_set = 1'b1;
            end else begin
                count_d = count_q - ONE_C;
            end
        end else if (do_repl) begin
            wr_en = 1'b1;
            if (is_empty) begin
                count_d = ONE_C;
            end else begin
                wr_idx = top_ptr[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_q | ovf_set;
            unf_q   <= unf_q | unf_set;
        end
    end

    // Storage is deliberately not reset; count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= bus.din;
        end
    end

    assign bus.tos   = (count_q >= ONE_C) ? mem[top_ptr[PW-1:0]] : '0;
    assign bus.nos   = (count_q >= TWO_C) ? mem[nos_ptr[PW-1:0]] : '0;
    assign bus.count = count_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: a queue-based reference model compared every cycle,
// plus hand-computed checks along the directed sequences.
module tb_operand_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_stack_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    bit         m_ovf  = 1'b0;
    bit         m_unf  = 1'b0;
    bit         cmp_en = 1'b0;

    function automatic logic [7:0] m_tos();
        return (mq.size() > 0) ? mq[mq.size()-1] : 8'h00;
    endfunction

    function automatic logic [7:0] m_nos();
        return (mq.size() > 1) ? mq[mq.size()-2] : 8'h00;
    endfunction

    function automatic void model_apply(input bit p, input bit q, input logic [7:0] d);
        case ({p, q})
            2'b10: if (mq.size() < DEPTH) mq.push_back(d); else m_ovf = 1'b1;
            2'b01: if (mq.size() > 0) void'(mq.pop_back()); else m_unf = 1'b1;
            2'b11: if (mq.size() > 0) mq[mq.size()-1] = d; else mq.push_back(d);
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_tos",   bus.tos,   m_tos());
            chk("cyc_nos",   bus.nos,   m_nos());
            chk("cyc_count", bus.count, mq.size());
            chk("cyc_empty", bus.empty, mq.size() == 0);
            chk("cyc_full",  bus.full,  mq.size() == DEPTH);
            chk("cyc_ovf",   bus.ovf,   m_ovf);
            chk("cyc_unf",   bus.unf,   m_unf);
        end
    end

    task automatic op(input bit p, input bit q, input logic [7:0] d);
        bus.push = p;
        bus.pop  = q;
        bus.din  = d;
        @(posedge clk);
        if (rst) model_apply(p, q, d);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.din  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_count", bus.count, 0);
        chk("init_empty", bus.empty, 1);
        #1;
        rst    = 1'b1;
        cmp_en = 1'b1;

        // push/push/add
        op(1, 0, 8'h08);
        op(1, 0, 8'h08);
        chk("add_tos", bus.tos, 8'h08);
        chk("add_nos", bus.nos, 8'h08);
        chk("add_count", bus.count, 2);
        op(0, 1, 8'h00);
        op(1, 1, 8'h10);
        chk("add_res_count", bus.count, 1);
        chk("add_res_tos", bus.tos, 8'h10);

        // sub to zero, then replace
        op(1, 0, 8'h10);
        chk("sub_nos", bus.nos, 8'h10);
        op(0, 1, 8'h00);
        op(1, 1, 8'h00);
        chk("sub_count", bus.count, 1);
        chk("sub_tos", bus.tos, 8'h00);
        op(1, 1, 8'hAA);
        chk("repl_tos", bus.tos, 8'hAA);
        chk("repl_count", bus.count, 1);

        // AND / NOT
        op(1, 0, 8'hAA);
        op(1, 0, 8'h66);
        chk("and_nos", bus.nos, 8'hAA);
        chk("and_tos", bus.tos, 8'h66);
        op(0, 1, 8'h00);
        op(1, 1, 8'h22);
        chk("and_res", bus.tos, 8'h22);
        op(1, 1, 8'hDD);
        chk("not_res", bus.tos, 8'hDD);
        chk("not_count", bus.count, 2);

        // asynchronous reset mid-cycle with count=3 and a push pending
        op(1, 0, 8'h01);
        chk("pre_rst_count", bus.count, 3);
        #2;
        bus.push = 1'b1;
        bus.din  = 8'h77;
        rst      = 1'b0;
        model_reset();
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_tos", bus.tos, 0);
        chk("rst_nos", bus.nos, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_unf", bus.unf, 0);
        @(posedge clk);
        #1;
        chk("rst_discard", bus.count, 0);
        bus.push = 1'b0;
        #1;
        rst = 1'b1;

        // overflow
        for (int i = 1; i <= DEPTH; i++) op(1, 0, 8'(i));
        chk("ovf_full", bus.full, 1);
        chk("ovf_tos8", bus.tos, 8'h08);
        op(1, 0, 8'hFF);
        chk("ovf_flag", bus.ovf, 1);
        chk("ovf_count", bus.count, 8);
        chk("ovf_tos", bus.tos, 8'h08);
        op(0, 1, 8'h00);
        chk("ovf_pop_full", bus.full, 0);
        chk("ovf_pop_tos", bus.tos, 8'h07);
        chk("ovf_sticky", bus.ovf, 1);

        // drain, underflow, replace on empty
        repeat (7) op(0, 1, 8'h00);
        chk("drain_empty", bus.empty, 1);
        chk("drain_tos", bus.tos, 0);
        op(0, 1, 8'h00);
        chk("unf_flag", bus.unf, 1);
        chk("unf_count", bus.count, 0);
        op(1, 1, 8'h5A);
        chk("rpe_count", bus.count, 1);
        chk("rpe_tos", bus.tos, 8'h5A);
        chk("rpe_unf", bus.unf, 1);
        chk("rpe_ovf", bus.ovf, 1);

        // reset clears sticky flags; first op after release takes effect
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst2_ovf", bus.ovf, 0);
        chk("rst2_unf", bus.unf, 0);
        chk("rst2_count", bus.count, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        op(1, 0, 8'h33);
        chk("post_rst_tos", bus.tos, 8'h33);
        chk("post_rst_count", bus.count, 1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
